ifetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory and downstream-facing to decode. It owns the fetch PC and drives the word-index address into instruction memory. It captures the returned 32-bit word into a small prefetch queue and presents instructions to decode with a valid/ready handshake. Decode or execute can redirect fetch at any time, which flushes the queue.

---
 rtl/ifetch_queue_if.sv | 34 +++
 rtl/ifetch_queue.sv | 80 ++++++++
 tb/tb_ifetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-side signal bundle: instruction-memory port, redirect request and decode handshake.
// master = the fetch stage, slave = memory/decode environment.
interface ifetch_queue_if;
    logic [10:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_a,
        input  imem_rd,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, buffers fetched words in a DEPTH-entry queue.
// Optional IFETCH_BYPASS_EN presents the memory word directly to decode when the queue is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_b,
    ifetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_word [DEPTH];

    logic        w_empty, w_valid, w_xfer, w_enq, w_pop, w_adv;
    logic [31:0] w_rpc;

    assign w_empty = (r_count == '0);
    assign w_rpc   = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_xfer  = w_valid && bus.instr_ready;

`ifdef IFETCH_BYPASS_EN
    logic w_byp, w_byp_take;

    // An empty queue forwards the live memory word; if decode takes it, it never enters the queue.
    assign w_byp      = w_empty && reset_b && !bus.redirect;
    assign w_byp_take = w_byp && bus.instr_ready;
    assign w_valid    = !w_empty || w_byp;
    assign w_pop      = w_xfer && !w_empty;
    assign w_enq      = !bus.redirect && !w_byp_take && ((r_count != FULL) || w_xfer);
    assign w_adv      = w_enq || w_byp_take;

    assign bus.instr    = w_empty ? (w_byp ? bus.imem_rd : 32'h0) : r_q_word[r_rptr];
    assign bus.instr_pc = w_empty ? (w_byp ? r_pc        : 32'h0) : r_q_pc[r_rptr];
`else
    assign w_valid = !w_empty;
    assign w_pop   = w_xfer;
    assign w_enq   = !bus.redirect && ((r_count != FULL) || w_xfer);
    assign w_adv   = w_enq;

    assign bus.instr    = w_empty ? 32'h0 : r_q_word[r_rptr];
    assign bus.instr_pc = w_empty ? 32'h0 : r_q_pc[r_rptr];
`endif

    assign bus.instr_valid = w_valid;
    assign bus.imem_a      = r_pc[12:2];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.redirect) begin
            // A transfer in this cycle is already consumed; everything queued behind it is stale.
            r_pc    <= w_rpc;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_adv) r_pc   <= r_pc + 32'd4;
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_pop};
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_wptr]   <= r_pc;
            r_q_word[r_wptr] <= bus.imem_rd;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory word k = 0x1000_0000 + k, table of per-cycle vectors
// plus hand-written sequences for asynchronous reset and the bypass build.
module tb_ifetch_queue;
    logic clk;
    logic reset_b;
    int   total;
    int   bad;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus.master)
    );

    assign bus.imem_rd = 32'h1000_0000 + {21'd0, bus.imem_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [10:0] exp_a;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic ready, input logic redir, input logic [31:0] rpc,
                       input logic exp_v, input logic [31:0] exp_pc, input logic [10:0] exp_a);
        vec_t v;
        v.rst_n = rst_n; v.ready = ready; v.redir = redir; v.rpc = rpc;
        v.exp_v = exp_v; v.exp_pc = exp_pc; v.exp_a = exp_a;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {21'd0, pc[12:2]};
    endfunction

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [10:0] a);
        chk({tag, " valid"},    {31'd0, bus.instr_valid}, {31'd0, v});
        chk({tag, " imem_a"},   {21'd0, bus.imem_a},      {21'd0, a});
        chk({tag, " instr_pc"}, bus.instr_pc,             v ? pc : 32'h0);
        chk({tag, " instr"},    bus.instr,                v ? word_of(pc) : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_b = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

`ifdef IFETCH_BYPASS_EN
        tick();
        tick();
        reset_b = 1'b1;
        #1;
        chk_out("byp_first", 1'b1, 32'h0, 11'h000);
        chk("byp_first count", {29'd0, dut.r_count}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("byp_k%0d", k), 1'b1, 32'(4 * k), 11'(k));
            chk($sformatf("byp_k%0d count", k), {29'd0, dut.r_count}, 32'd0);
        end
`else
        // reset, streaming start
        add(0, 1, 0, 0, 0, 32'h0,    11'h000);
        add(0, 1, 0, 0, 0, 32'h0,    11'h000);
        add(1, 1, 0, 0, 0, 32'h0,    11'h000);
        add(1, 1, 0, 0, 1, 32'h0,    11'h001);
        add(1, 1, 0, 0, 1, 32'h4,    11'h002);
        add(1, 1, 0, 0, 1, 32'h8,    11'h003);
        add(1, 1, 0, 0, 1, 32'hC,    11'h004);
        // back-pressure: 10 cycles with ready low; imem_a freezes once the queue holds 4
        add(1, 0, 0, 0, 1, 32'h10,   11'h005);
        add(1, 0, 0, 0, 1, 32'h10,   11'h006);
        add(1, 0, 0, 0, 1, 32'h10,   11'h007);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 0, 1, 32'h10, 11'h008);
        // release: PCs continue in order with the queue staying full
        add(1, 1, 0, 0, 1, 32'h10,   11'h008);
        add(1, 1, 0, 0, 1, 32'h14,   11'h009);
        add(1, 1, 0, 0, 1, 32'h18,   11'h00A);
        add(1, 1, 0, 0, 1, 32'h1C,   11'h00B);
        // redirect with full queue and a transfer
        add(1, 1, 1, 32'h0000_0103, 1, 32'h20, 11'h00C);
        add(1, 1, 0, 0, 0, 32'h0,    11'h040);
        add(1, 1, 0, 0, 1, 32'h100,  11'h041);
        // redirect to the top of the word space
        add(1, 1, 1, 32'h0000_1FFC, 1, 32'h104, 11'h042);
        add(1, 1, 0, 0, 0, 32'h0,    11'h7FF);
        add(1, 1, 0, 0, 1, 32'h1FFC, 11'h000);
        // build count = 3 for the async reset sequence
        add(1, 0, 0, 0, 1, 32'h2000, 11'h001);
        add(1, 0, 0, 0, 1, 32'h2000, 11'h002);

        for (int i = 0; i < tbl.size(); i++) begin
            reset_b         = tbl[i].rst_n;
            bus.instr_ready = tbl[i].ready;
            bus.redirect    = tbl[i].redir;
            bus.redirect_pc = tbl[i].rpc;
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].exp_v, tbl[i].exp_pc, tbl[i].exp_a);
            tick();
        end

        // async reset between edges with three entries queued
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        #1;
        chk_out("pre_arst", 1'b1, 32'h2000, 11'h003);
        reset_b = 1'b0;
        #1;
        chk_out("arst_now", 1'b0, 32'h0, 11'h000);
        tick();
        chk_out("arst_hold", 1'b0, 32'h0, 11'h000);
        reset_b = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        chk_out("restart0", 1'b0, 32'h0, 11'h000);
        tick();
        chk_out("restart1", 1'b1, 32'h0, 11'h001);
        tick();
        chk_out("restart2", 1'b1, 32'h4, 11'h002);
        tick();
        chk_out("restart3", 1'b1, 32'h8, 11'h003);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
